regfile_bist_ctrl: RTL and testbench

Built-in self-test initiator for the 4-entry × 4-bit register file. On a start pulse it drives the register file's write port to fill every entry with a seeded pattern, then drives the read port to read every entry back and compares each returned word against the expected value. It reports pass/fail, the first failing address and the mismatch count. It sits between the lab's top-level test controller and the register file, acting as the initiator side of the register-file write/read interface.

---
 rtl/regfile_pkg.sv | 34 +++
 rtl/regfile_bist_cmp.sv | 75 +++++++
 rtl/regfile_bist_ctrl.sv | 124 ++++++++++++
 tb/tb_regfile_bist_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, sizes and test-pattern function for the register-file BIST.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int ERR_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Tag travelling alongside an outstanding read, consumed one cycle later.
    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
    } rsp_tag_t;

    // Expected word for address k: (seed + k) mod 2**DATA_W, optionally inverted.
    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] seed,
                                                  input logic [ADDR_W-1:0] k,
                                                  input logic              invert);
        logic [DATA_W-1:0] p;
        p = seed + DATA_W'(k);
        return invert ? ~p : p;
    endfunction

endpackage

// File: rtl/regfile_bist_cmp.sv
// Read-response tag register plus compare/accumulate of pass, first fail address and error count.
// Latency: read issued in cycle N is compared in cycle N+1; results visible in cycle N+2.
// Backpressure: none; every tagged response is compared in the cycle it arrives.
module regfile_bist_cmp
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic              invert_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              pass_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [ERR_W-1:0]  err_count_o
);

    rsp_tag_t          tag_q;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              mismatch;

    // Remember which address was read so its data can be checked next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q.vld  <= rd_en_i;
            tag_q.addr <= rd_addr_i;
        end
    end

    // Compare the returning word and fold it into the running result; a new start wins.
    always_comb begin
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        err_cnt_d   = err_cnt_q;
        mismatch    = tag_q.vld && (rd_data_i != pattern(seed_i, tag_q.addr, invert_i));
        if (clr_i) begin
            pass_d      = 1'b1;
            fail_addr_d = '0;
            err_cnt_d   = '0;
        end else if (mismatch) begin
            pass_d = 1'b0;
            // A zero count means no earlier mismatch in this run.
            if (err_cnt_q == '0) begin
                fail_addr_d = tag_q.addr;
            end
            if (err_cnt_q != ERR_W'(DEPTH)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    // Result registers, held between runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign pass_o      = pass_q;
    assign fail_addr_o = fail_addr_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: rtl/regfile_bist_ctrl.sv
// BIST initiator: fills the register file with a seeded pattern, reads it back, reports pass/fail.
// Latency: start accepted at edge E0 -> done pulse in cycle 2*DEPTH+2 (cycle 10 for DEPTH=4).
// Backpressure: none; start is ignored outside IDLE and the register file is assumed always ready.
module regfile_bist_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    input  logic              invert,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ERR_W-1:0]  err_count,
    output logic [DATA_W-1:0] rf_data_in,
    output logic [ADDR_W-1:0] rf_write_add,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_read_add,
    output logic              rf_read_en,
    input  logic [DATA_W-1:0] rf_data_out
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              invert_q, invert_d;
    logic              start_acc;

    // State, address counter and captured test configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            seed_q   <= '0;
            invert_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seed_q   <= seed_d;
            invert_q <= invert_d;
        end
    end

    // Next-state sequencing and output decode from state/cnt.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seed_d       = seed_q;
        invert_d     = invert_q;
        start_acc    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        rf_data_in   = '0;
        rf_write_add = '0;
        rf_write_en  = 1'b0;
        rf_read_add  = '0;
        rf_read_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    seed_d    = seed;
                    invert_d  = invert;
                    cnt_d     = '0;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                busy         = 1'b1;
                rf_write_en  = 1'b1;
                rf_write_add = cnt_q;
                rf_data_in   = pattern(seed_q, cnt_q, invert_q);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                busy        = 1'b1;
                rf_read_en  = 1'b1;
                rf_read_add = cnt_q;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // Last read response is compared this cycle.
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    regfile_bist_cmp u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (start_acc),
        .rd_en_i     (rf_read_en),
        .rd_addr_i   (rf_read_add),
        .seed_i      (seed_q),
        .invert_i    (invert_q),
        .rd_data_i   (rf_data_out),
        .pass_o      (pass),
        .fail_addr_o (fail_addr),
        .err_count_o (err_count)
    );

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Self-checking bench for regfile_bist_ctrl with a faultable register-file model.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  seed;
    logic        invert;
    logic        busy, done, pass;
    logic [1:0]  fail_addr;
    logic [2:0]  err_count;
    logic [3:0]  rf_data_in;
    logic [1:0]  rf_write_add;
    logic        rf_write_en;
    logic [1:0]  rf_read_add;
    logic        rf_read_en;
    logic [3:0]  rf_data_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_bist_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .seed         (seed),
        .invert       (invert),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_addr    (fail_addr),
        .err_count    (err_count),
        .rf_data_in   (rf_data_in),
        .rf_write_add (rf_write_add),
        .rf_write_en  (rf_write_en),
        .rf_read_add  (rf_read_add),
        .rf_read_en   (rf_read_en),
        .rf_data_out  (rf_data_out)
    );

    // Register file model: synchronous write, registered 1-cycle read.
    // fault_mask nibble k holds bits of address k stuck at 0.
    logic [15:0] fault_mask;
    logic [3:0]  mem [4];
    logic [3:0]  rd_q;

    always @(posedge clk) begin
        if (rf_write_en)
            mem[rf_write_add] <= rf_data_in & ~fault_mask[int'(rf_write_add)*4 +: 4];
        if (rf_read_en)
            rd_q <= mem[rf_read_add];
    end
    assign rf_data_out = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: pattern word for address k from plain integer arithmetic.
    function automatic logic [3:0] ref_pat(input int sd, input int inv, input int k);
        int v;
        v = (sd + k) % 16;
        if (inv != 0) v = 15 - v;
        return v[3:0];
    endfunction

    // Reference: outcome of a whole test against a faulty memory.
    task automatic ref_result(input int sd, input int inv, input logic [15:0] m,
                              output logic [15:0] wr, output logic ps,
                              output logic [1:0] fa, output logic [2:0] ec);
        int cnt;
        int first;
        logic [3:0] e;
        cnt   = 0;
        first = 0;
        wr    = '0;
        for (int k = 0; k < 4; k++) begin
            e = ref_pat(sd, inv, k);
            wr[k*4 +: 4] = e;
            if ((e & ~m[k*4 +: 4]) != e) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
        ps = (cnt == 0);
        fa = first[1:0];
        ec = cnt[2:0];
    endtask

    // One full test: start, observe every cycle up to done, then check results are held.
    task automatic run_test(input string name, input logic [3:0] sd, input logic inv,
                            input logic [15:0] m, input logic [15:0] exp_wr,
                            input logic exp_pass, input logic [1:0] exp_fa,
                            input logic [2:0] exp_ec, input int poke_cyc);
        int   done_cyc, busy_n, wr_n, rd_n, extra_done;
        logic wr_ok, rd_ok, overlap, held;
        logic g_pass;
        logic [1:0] g_fa;
        logic [2:0] g_ec;
        done_cyc = 0; busy_n = 0; wr_n = 0; rd_n = 0; extra_done = 0;
        wr_ok = 1'b1; rd_ok = 1'b1; overlap = 1'b0; held = 1'b1;
        g_pass = 1'b0; g_fa = '0; g_ec = '0;
        fault_mask = m;
        @(negedge clk);
        seed   = sd;
        invert = inv;
        start  = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 30 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            start = (cyc == poke_cyc);
            if (busy) busy_n++;
            if (rf_write_en && rf_read_en) overlap = 1'b1;
            if (rf_write_en) begin
                if (wr_n >= 4 || cyc != wr_n + 1 || rf_write_add != wr_n[1:0] ||
                    rf_data_in != exp_wr[wr_n*4 +: 4])
                    wr_ok = 1'b0;
                wr_n++;
            end
            if (rf_read_en) begin
                if (rd_n >= 4 || cyc != rd_n + 5 || rf_read_add != rd_n[1:0])
                    rd_ok = 1'b0;
                rd_n++;
            end
            if (done) begin
                done_cyc = cyc;
                g_pass   = pass;
                g_fa     = fail_addr;
                g_ec     = err_count;
            end
        end
        start = 1'b0;
        chk({name, " done_cycle"}, done_cyc, 10);
        chk({name, " pass"}, g_pass, exp_pass);
        chk({name, " fail_addr"}, g_fa, exp_fa);
        chk({name, " err_count"}, g_ec, exp_ec);
        chk({name, " writes"}, {wr_ok, 28'd0, wr_n[2:0]}, {1'b1, 28'd0, 3'd4});
        chk({name, " reads"}, {rd_ok, 28'd0, rd_n[2:0]}, {1'b1, 28'd0, 3'd4});
        chk({name, " busy_cycles"}, busy_n, 9);
        chk({name, " wr_rd_overlap"}, overlap, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy || pass != exp_pass || fail_addr != exp_fa || err_count != exp_ec)
                held = 1'b0;
        end
        chk({name, " extra_done"}, extra_done, 0);
        chk({name, " results_held"}, held, 1'b1);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  sd;
        logic        inv;
        logic [15:0] mask;
        logic [15:0] exp_wr;
        logic        exp_pass;
        logic [1:0]  exp_fa;
        logic [2:0]  exp_ec;
        int          poke;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [15:0] r_wr;
        logic        r_ps;
        logic [1:0]  r_fa;
        logic [2:0]  r_ec;
        int          rs, ri, nd;
        logic [15:0] rm;

        // Hand-derived expectations; exp_wr packs {addr3, addr2, addr1, addr0}.
        vecs[0] = '{"good",        4'h1, 1'b0, 16'h0000, 16'h4321, 1'b1, 2'd0, 3'd0, 0};
        vecs[1] = '{"wrap_invert", 4'hE, 1'b1, 16'h0000, 16'hEF01, 1'b1, 2'd0, 3'd0, 0};
        vecs[2] = '{"stuck_bit",   4'h8, 1'b0, 16'h0080, 16'hBA98, 1'b0, 2'd1, 3'd1, 0};
        vecs[3] = '{"multi_fault", 4'h8, 1'b0, 16'h8800, 16'hBA98, 1'b0, 2'd2, 3'd2, 0};
        vecs[4] = '{"all_fault",   4'h0, 1'b1, 16'hFFFF, 16'hCDEF, 1'b0, 2'd0, 3'd4, 0};
        vecs[5] = '{"start_in_rd", 4'h3, 1'b0, 16'h0000, 16'h6543, 1'b1, 2'd0, 3'd0, 6};

        rst_n = 1'b0; start = 1'b0; seed = '0; invert = 1'b0; fault_mask = '0;
        #1;
        chk("reset_outputs",
            {busy, done, pass, fail_addr, err_count, rf_data_in, rf_write_add,
             rf_write_en, rf_read_add, rf_read_en}, 18'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs",
            {busy, done, pass, fail_addr, err_count, rf_data_in, rf_write_add,
             rf_write_en, rf_read_add, rf_read_en}, 18'd0);

        foreach (vecs[i])
            run_test(vecs[i].name, vecs[i].sd, vecs[i].inv, vecs[i].mask, vecs[i].exp_wr,
                     vecs[i].exp_pass, vecs[i].exp_fa, vecs[i].exp_ec, vecs[i].poke);

        // Randomized seeds, polarities and stuck-at-0 faults against the reference.
        for (int t = 0; t < 10; t++) begin
            rs = $urandom_range(0, 15);
            ri = $urandom_range(0, 1);
            rm = '0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) rm[k*4 +: 4] = 4'($urandom_range(1, 15));
            ref_result(rs, ri, rm, r_wr, r_ps, r_fa, r_ec);
            run_test($sformatf("rand%0d", t), rs[3:0], ri[0], rm, r_wr, r_ps, r_fa, r_ec, 0);
        end

        // Reset asserted in cycle 6 of a run with a fault present.
        fault_mask = 16'h0080;
        @(negedge clk);
        seed = 4'h8; invert = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy_before_reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs",
            {busy, done, pass, fail_addr, err_count, rf_data_in, rf_write_add,
             rf_write_en, rf_read_add, rf_read_en}, 18'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy || pass || err_count != 0) nd++;
        end
        chk("no_activity_after_reset", nd, 0);
        run_test("restart", 4'h8, 1'b0, 16'h0000, 16'hBA98, 1'b1, 2'd0, 3'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
